transmission_estimation_pipe: RTL and testbench
===============================================

Name: transmission_estimation_pipe

Overview:
Parametrised successor to the 3x3 transmission estimator in the dehazing datapath. It sits between the window generator and the scene-recovery stage. For each pixel it takes one 3x3 window per channel and computes t = ONE − (min_c(P_sel,c) · invA_c >> SHIFT), then clamps t to at least T_MIN. Compared with the earlier estimator, it adds valid/ready flow control with backpressure, per-frame latching of inverse atmospheric light, a programmable edge threshold, a forced-filter mode, and frame sideband flags.

Parameters:
- DW, 8, pixel width per channel.
- INV_W, 9, width of each inverse atmospheric light value.
- OUT_W, 12, transmission width; ONE = 2^OUT_W − 1.
- SHIFT, 5, right shift applied to the product; default equals DW+INV_W−OUT_W.
- EDGE_TH, 32, gradient threshold for edge classification; valid range 0..2^DW−1.
- T_MIN, 409, lower clamp on t (≈0.1 in Q0.12).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- in_valid, in, 1, input window valid.
- in_ready, out, 1, block can accept a window.
- win_r, in, 9*DW, red 3x3 window; element k at [k*DW +: DW], raster order 0..8, centre = 4.
- win_g, in, 9*DW, green window, same layout.
- win_b, in, 9*DW, blue window, same layout.
- in_sof, in, 1, first pixel of frame.
- in_eof, in, 1, last pixel of frame.
- mode, in, 2, 0 = edge-adaptive, 1 = force P0, 2 = force P1, 3 = force P2.
- inv_a_r, in, INV_W, red inverse atmospheric light.
- inv_a_g, in, INV_W, green inverse atmospheric light.
- inv_a_b, in, INV_W, blue inverse atmospheric light.
- out_valid, out, 1, t_out valid.
- out_ready, in, 1, downstream accepts.
- t_out, out, OUT_W, transmission value.
- out_sof, out, 1, sof aligned with t_out.
- out_eof, out, 1, eof aligned with t_out.
- frame_done, out, 1, one-cycle pulse when the eof beat is accepted downstream.

Behaviour:
- Reset (rst=0, async): all pipeline valids = 0, out_valid = 0, t_out = 0, out_sof = out_eof = frame_done = 0, latched invA = {0,0,0}. Asserting reset mid-frame discards all in-flight beats.
- Flow control: en = !out_valid || out_ready; in_ready = en. All stages advance together when en=1 and hold (data and valid) when en=0. Bubbles propagate as valid = 0.
- Latency: 3 accepted-clock stages from input handshake to out_valid. Full throughput is 1 pixel/clk while out_ready=1.
- invA latching: on a handshake with in_sof=1, inv_a_* is captured and that beat uses the newly captured values. All later beats use the latched values until the next sof. inv_a_* changing mid-frame has no effect.
- Stage 1, per channel:
  - P0 = min of all 9 elements; P1 = min(e1,e4,e7), the column; P2 = min(e3,e4,e5), the row.
  - gv = |e1−e7|, gh = |e3−e5|.
  - Class = 00 if max(gv,gh) ≤ EDGE_TH; else 01 if gv ≥ gh; else 10.
  - Register P0/P1/P2, classes, mode, sof, eof, and latched invA.
- Stage 2: filter selection and channel minimum.
  - cls = OR of the three channel classes.
  - When mode=0, the filter is chosen from cls: 00 → P0, 01 → P2, 10 → P1, 11 → P0.
  - When mode≠0, the forced filter is used regardless of cls.
  - Pick the channel with the smallest selected P; ties resolve to the lowest index (R, then G, then B).
  - Register p_sel (DW) and the matching inv_sel (INV_W).
- Stage 3: arithmetic and clamp.
  - prod = p_sel·inv_sel (DW+INV_W bits, unsigned).
  - sc = prod >> SHIFT.
  - t_raw = ONE − min(sc, ONE).
  - t_out = max(t_raw, T_MIN).
- Sideband: out_sof and out_eof travel with their beat through every stage.
  - frame_done = out_valid & out_ready & out_eof, registered, so it pulses the following cycle.
- Simultaneous in_sof and in_eof on one beat (single-pixel frame): both flags propagate, and that beat latches invA.
- out_valid=1 with out_ready=0: t_out and the sideband flags must stay stable until accepted.

Test Plan:
- Flat window, all channels = 100; invA = {256,300,300}; mode 0 → cls 00, P0 selected, R chosen by tie rule. prod 25600, sc 800, t_out = 3295 three cycles after the handshake.
- Red e1=0, e7=200, all other red elements 150; G and B flat at 200; invA = 256 → cls 01, P2 selected (red P2 = 150, G/B = 200). Red chosen, sc 1200, t_out = 2895. Same stimulus with mode=1 → P0 = 0, t_out = 4095.
- All elements 255, invA = 511 → sc 4072, t_raw 23, t_out clamped to 409.
- Stream of 8 beats with out_ready toggled 1,0,0,1,… → no beats lost or duplicated. t_out is held stable while stalled, and in_ready mirrors en.
- sof beat with invA = 256, then invA driven to 100 mid-frame → later beats still use 256. The next sof captures 100. frame_done pulses once per eof acceptance.
- Reset asserted with 2 beats in flight → out_valid drops immediately and no stale output follows. After release, the first output appears 3 cycles after a new handshake.

Source files
------------

// File: rtl/transmission_estimation_pipe_if.sv
// ----------------------------------------------------------------------------
// transmission_estimation_pipe_if
// Streaming bundle for the transmission estimator: the input window stream
// (valid/ready, three 3x3 windows, sof/eof) and the output transmission stream
// (valid/ready, t_out, sof/eof).
//   master : the environment side (drives windows, consumes t_out)
//   slave  : the estimator side (accepts windows, produces t_out)
// ----------------------------------------------------------------------------
interface transmission_estimation_pipe_if #(
    parameter int DW    = 8,
    parameter int OUT_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [9*DW-1:0]   win_r;
    logic [9*DW-1:0]   win_g;
    logic [9*DW-1:0]   win_b;
    logic              in_sof;
    logic              in_eof;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  t_out;
    logic              out_sof;
    logic              out_eof;

    modport master (
        output in_valid, win_r, win_g, win_b, in_sof, in_eof, out_ready,
        input  in_ready, out_valid, t_out, out_sof, out_eof
    );

    modport slave (
        input  in_valid, win_r, win_g, win_b, in_sof, in_eof, out_ready,
        output in_ready, out_valid, t_out, out_sof, out_eof
    );
endinterface

// File: rtl/transmission_estimation_pipe.sv
// ----------------------------------------------------------------------------
// transmission_estimation_pipe
// Three-stage transmission estimator for the dehazing datapath.
//   t = ONE - min(min_c(P_sel,c) * invA_c >> SHIFT, ONE), clamped to >= T_MIN.
// Stage 1: per-channel 3x3 minimum filters (full, column, row) and edge class.
// Stage 2: filter choice (edge-adaptive or forced) and darkest-channel pick.
// Stage 3: multiply, shift, invert and clamp.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   bus (slave)     window input stream and t_out output stream
//   mode            0 edge-adaptive, 1/2/3 force P0/P1/P2
//   inv_a_r/g/b     inverse atmospheric light, captured on each sof beat
//   frame_done      one-cycle pulse after the eof beat leaves the block
// ----------------------------------------------------------------------------
module transmission_estimation_pipe #(
    parameter int DW      = 8,
    parameter int INV_W   = 9,
    parameter int OUT_W   = 12,
    parameter int SHIFT   = 5,
    parameter int EDGE_TH = 32,
    parameter int T_MIN   = 409
) (
    input  logic                 clk,
    input  logic                 rst,
    transmission_estimation_pipe_if.slave bus,
    input  logic [1:0]           mode,
    input  logic [INV_W-1:0]     inv_a_r,
    input  logic [INV_W-1:0]     inv_a_g,
    input  logic [INV_W-1:0]     inv_a_b,
    output logic                 frame_done
);
    localparam int PW = DW + INV_W;
    // Arithmetic width wide enough for both the product and ONE.
    localparam int CW = (PW > OUT_W) ? PW : OUT_W;
    localparam logic [CW-1:0] ONE_C  = CW'((1 << OUT_W) - 1);
    localparam logic [CW-1:0] TMIN_C = CW'(T_MIN);
    localparam logic [DW-1:0] TH_C   = DW'(EDGE_TH);

    function automatic logic [DW-1:0] min2(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DW-1:0] absdiff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    // ------------------------------------------------------------------
    // Flow control: every stage moves together whenever the output slot
    // is empty or being drained.
    // ------------------------------------------------------------------
    logic en;
    logic acc;
    logic out_valid_q, out_valid_d;

    assign en           = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;
    assign acc          = bus.in_valid && en;

    // ------------------------------------------------------------------
    // Inverse atmospheric light: a sof beat uses the live inputs and
    // captures them for the rest of the frame.
    // ------------------------------------------------------------------
    logic [INV_W-1:0] inv_in     [3];
    logic [INV_W-1:0] inv_lat_q  [3];
    logic [INV_W-1:0] inv_lat_d  [3];
    logic [INV_W-1:0] inv_beat   [3];
    logic [9*DW-1:0]  win        [3];

    assign inv_in[0] = inv_a_r;
    assign inv_in[1] = inv_a_g;
    assign inv_in[2] = inv_a_b;
    assign win[0]    = bus.win_r;
    assign win[1]    = bus.win_g;
    assign win[2]    = bus.win_b;

    always_comb begin
        inv_lat_d = inv_lat_q;
        if (acc && bus.in_sof) begin
            inv_lat_d = inv_in;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1 combinational: per-channel filters and edge class.
    // ------------------------------------------------------------------
    logic [DW-1:0] p0_c  [3];
    logic [DW-1:0] p1_c  [3];
    logic [DW-1:0] p2_c  [3];
    logic [1:0]    cls_c [3];

    genvar gi, gk;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ch
            logic [DW-1:0] e [9];
            logic [DW-1:0] gv;
            logic [DW-1:0] gh;

            for (gk = 0; gk < 9; gk++) begin : g_el
                assign e[gk] = win[gi][gk*DW +: DW];
            end

            assign inv_beat[gi] = bus.in_sof ? inv_in[gi] : inv_lat_q[gi];

            assign p0_c[gi] = min2(min2(min2(e[0], e[1]), min2(e[2], e[3])),
                                   min2(min2(e[4], e[5]), min2(min2(e[6], e[7]), e[8])));
            assign p1_c[gi] = min2(min2(e[1], e[4]), e[7]);
            assign p2_c[gi] = min2(min2(e[3], e[4]), e[5]);

            assign gv = absdiff(e[1], e[7]);
            assign gh = absdiff(e[3], e[5]);

            // 01 = vertical gradient dominates, 10 = horizontal dominates.
            always_comb begin
                if (gv <= TH_C && gh <= TH_C) begin
                    cls_c[gi] = 2'b00;
                end else if (gv >= gh) begin
                    cls_c[gi] = 2'b01;
                end else begin
                    cls_c[gi] = 2'b10;
                end
            end
        end
    endgenerate

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [DW-1:0]    s1_p0_q  [3], s1_p0_d  [3];
    logic [DW-1:0]    s1_p1_q  [3], s1_p1_d  [3];
    logic [DW-1:0]    s1_p2_q  [3], s1_p2_d  [3];
    logic [1:0]       s1_cls_q [3], s1_cls_d [3];
    logic [INV_W-1:0] s1_inv_q [3], s1_inv_d [3];
    logic [1:0]       s1_mode_q, s1_mode_d;
    logic             s1_sof_q, s1_sof_d;
    logic             s1_eof_q, s1_eof_d;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_p0_d    = s1_p0_q;
        s1_p1_d    = s1_p1_q;
        s1_p2_d    = s1_p2_q;
        s1_cls_d   = s1_cls_q;
        s1_inv_d   = s1_inv_q;
        s1_mode_d  = s1_mode_q;
        s1_sof_d   = s1_sof_q;
        s1_eof_d   = s1_eof_q;
        if (en) begin
            s1_valid_d = bus.in_valid;
            s1_p0_d    = p0_c;
            s1_p1_d    = p1_c;
            s1_p2_d    = p2_c;
            s1_cls_d   = cls_c;
            s1_inv_d   = inv_beat;
            s1_mode_d  = mode;
            s1_sof_d   = bus.in_sof;
            s1_eof_d   = bus.in_eof;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: filter choice and darkest channel.
    // ------------------------------------------------------------------
    logic [1:0]       cls_or;
    logic [1:0]       filt;
    logic [DW-1:0]    psel_ch [3];
    logic [DW-1:0]    p_pick;
    logic [INV_W-1:0] inv_pick;

    assign cls_or = s1_cls_q[0] | s1_cls_q[1] | s1_cls_q[2];

    // filt: 0 = P0 (full), 1 = P1 (column), 2 = P2 (row).
    // A vertical gradient is smoothed along the row, a horizontal one
    // along the column; mixed or flat windows fall back to the full min.
    always_comb begin
        filt = 2'd0;
        if (s1_mode_q != 2'd0) begin
            filt = s1_mode_q - 2'd1;
        end else begin
            case (cls_or)
                2'b01:   filt = 2'd2;
                2'b10:   filt = 2'd1;
                default: filt = 2'd0;
            endcase
        end
    end

    generate
        for (gi = 0; gi < 3; gi++) begin : g_sel
            assign psel_ch[gi] = (filt == 2'd0) ? s1_p0_q[gi] :
                                 (filt == 2'd1) ? s1_p1_q[gi] : s1_p2_q[gi];
        end
    endgenerate

    // Non-strict compares so equal values resolve towards R, then G.
    always_comb begin
        p_pick   = psel_ch[2];
        inv_pick = s1_inv_q[2];
        if (psel_ch[0] <= psel_ch[1] && psel_ch[0] <= psel_ch[2]) begin
            p_pick   = psel_ch[0];
            inv_pick = s1_inv_q[0];
        end else if (psel_ch[1] <= psel_ch[2]) begin
            p_pick   = psel_ch[1];
            inv_pick = s1_inv_q[1];
        end
    end

    // Stage 2 registers
    logic             s2_valid_q, s2_valid_d;
    logic [DW-1:0]    s2_p_q, s2_p_d;
    logic [INV_W-1:0] s2_inv_q, s2_inv_d;
    logic             s2_sof_q, s2_sof_d;
    logic             s2_eof_q, s2_eof_d;

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_p_d     = s2_p_q;
        s2_inv_d   = s2_inv_q;
        s2_sof_d   = s2_sof_q;
        s2_eof_d   = s2_eof_q;
        if (en) begin
            s2_valid_d = s1_valid_q;
            s2_p_d     = p_pick;
            s2_inv_d   = inv_pick;
            s2_sof_d   = s1_sof_q;
            s2_eof_d   = s1_eof_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3 combinational: product, shift, invert, clamp.
    // ------------------------------------------------------------------
    logic [PW-1:0] prod;
    logic [CW-1:0] sc;
    logic [CW-1:0] t_raw;
    logic [CW-1:0] t_clamp;

    assign prod    = PW'(s2_p_q) * PW'(s2_inv_q);
    assign sc      = CW'(prod >> SHIFT);
    assign t_raw   = ONE_C - ((sc > ONE_C) ? ONE_C : sc);
    assign t_clamp = (t_raw < TMIN_C) ? TMIN_C : t_raw;

    // Output registers
    logic [OUT_W-1:0] t_out_q, t_out_d;
    logic             out_sof_q, out_sof_d;
    logic             out_eof_q, out_eof_d;
    logic             frame_done_q, frame_done_d;

    always_comb begin
        out_valid_d = out_valid_q;
        t_out_d     = t_out_q;
        out_sof_d   = out_sof_q;
        out_eof_d   = out_eof_q;
        if (en) begin
            out_valid_d = s2_valid_q;
            t_out_d     = OUT_W'(t_clamp);
            out_sof_d   = s2_sof_q;
            out_eof_d   = s2_eof_q;
        end
        frame_done_d = out_valid_q && bus.out_ready && out_eof_q;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                inv_lat_q[i] <= '0;
                s1_p0_q[i]   <= '0;
                s1_p1_q[i]   <= '0;
                s1_p2_q[i]   <= '0;
                s1_cls_q[i]  <= '0;
                s1_inv_q[i]  <= '0;
            end
            s1_valid_q   <= 1'b0;
            s1_mode_q    <= '0;
            s1_sof_q     <= 1'b0;
            s1_eof_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_p_q       <= '0;
            s2_inv_q     <= '0;
            s2_sof_q     <= 1'b0;
            s2_eof_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            t_out_q      <= '0;
            out_sof_q    <= 1'b0;
            out_eof_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            inv_lat_q    <= inv_lat_d;
            s1_valid_q   <= s1_valid_d;
            s1_p0_q      <= s1_p0_d;
            s1_p1_q      <= s1_p1_d;
            s1_p2_q      <= s1_p2_d;
            s1_cls_q     <= s1_cls_d;
            s1_inv_q     <= s1_inv_d;
            s1_mode_q    <= s1_mode_d;
            s1_sof_q     <= s1_sof_d;
            s1_eof_q     <= s1_eof_d;
            s2_valid_q   <= s2_valid_d;
            s2_p_q       <= s2_p_d;
            s2_inv_q     <= s2_inv_d;
            s2_sof_q     <= s2_sof_d;
            s2_eof_q     <= s2_eof_d;
            out_valid_q  <= out_valid_d;
            t_out_q      <= t_out_d;
            out_sof_q    <= out_sof_d;
            out_eof_q    <= out_eof_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.t_out     = t_out_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eof   = out_eof_q;
    assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_transmission_estimation_pipe.sv
// ----------------------------------------------------------------------------
// tb_transmission_estimation_pipe
// Directed bench for transmission_estimation_pipe with hand-computed results.
// ----------------------------------------------------------------------------
module tb_transmission_estimation_pipe;
    localparam int DW    = 8;
    localparam int INV_W = 9;
    localparam int OUT_W = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       mode;
    logic [INV_W-1:0] inv_r, inv_g, inv_b;
    logic             frame_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    transmission_estimation_pipe_if #(.DW(DW), .OUT_W(OUT_W)) bus ();

    transmission_estimation_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .mode       (mode),
        .inv_a_r    (inv_r),
        .inv_a_g    (inv_g),
        .inv_a_b    (inv_b),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9*DW-1:0] flat(input logic [DW-1:0] v);
        return {9{v}};
    endfunction

    // Window of 'base' with the four gradient taps overridden.
    function automatic logic [9*DW-1:0] mk_win(input logic [DW-1:0] base,
                                               input logic [DW-1:0] e1, input logic [DW-1:0] e7,
                                               input logic [DW-1:0] e3, input logic [DW-1:0] e5);
        logic [9*DW-1:0] w;
        w = {9{base}};
        w[1*DW +: DW] = e1;
        w[7*DW +: DW] = e7;
        w[3*DW +: DW] = e3;
        w[5*DW +: DW] = e5;
        return w;
    endfunction

    // One isolated beat through an empty pipe; checks latency, value,
    // sideband, frame_done and that nothing follows it.
    task automatic send_one(input string tag, input logic [1:0] m,
                            input logic [9*DW-1:0] wr, input logic [9*DW-1:0] wg,
                            input logic [9*DW-1:0] wb,
                            input logic [INV_W-1:0] ir, input logic [INV_W-1:0] ig,
                            input logic [INV_W-1:0] ib,
                            input logic sof, input logic eof, input int exp_t);
        int n;
        mode          = m;
        bus.win_r     = wr;
        bus.win_g     = wg;
        bus.win_b     = wb;
        inv_r         = ir;
        inv_g         = ig;
        inv_b         = ib;
        bus.in_sof    = sof;
        bus.in_eof    = eof;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        #1;
        chk({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eof   = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, n, 3);
        chk({tag, "_t"}, bus.t_out, exp_t);
        chk({tag, "_sof"}, bus.out_sof, sof);
        chk({tag, "_eof"}, bus.out_eof, eof);
        $display("txn %s t_out=%0d latency=%0d sof=%0d eof=%0d", tag, bus.t_out, n, bus.out_sof, bus.out_eof);
        @(posedge clk); #1;
        chk({tag, "_frame_done"}, frame_done, eof);
        chk({tag, "_no_dup"}, bus.out_valid, 0);
    endtask

    initial begin
        int tx, rx, cyc;
        logic stall;
        logic [OUT_W-1:0] held;
        logic hs_in, hs_out;
        bit pat [4];

        bus.in_valid  = 1'b0;
        bus.in_sof    = 1'b0;
        bus.in_eof    = 1'b0;
        bus.out_ready = 1'b0;
        bus.win_r     = '0;
        bus.win_g     = '0;
        bus.win_b     = '0;
        mode          = 2'd0;
        inv_r         = '0;
        inv_g         = '0;
        inv_b         = '0;

        // Reset state
        #12;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_t_out", bus.t_out, 0);
        chk("rst_flags", {bus.out_sof, bus.out_eof, frame_done}, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        // Flat window: tie resolves to red (invA 256): 25600>>5=800 -> 3295
        send_one("flat100", 2'd0, flat(8'd100), flat(8'd100), flat(8'd100),
                 9'd256, 9'd300, 9'd300, 1'b1, 1'b0, 3295);

        // Vertical edge on red: cls 01 -> P2=150 -> 38400>>5=1200 -> 2895
        send_one("vedge_m0", 2'd0, mk_win(8'd150, 8'd0, 8'd200, 8'd150, 8'd150),
                 flat(8'd200), flat(8'd200), 9'd256, 9'd256, 9'd256, 1'b1, 1'b0, 2895);
        // Forced P0 -> red min 0 -> 4095
        send_one("vedge_m1", 2'd1, mk_win(8'd150, 8'd0, 8'd200, 8'd150, 8'd150),
                 flat(8'd200), flat(8'd200), 9'd256, 9'd256, 9'd256, 1'b1, 1'b0, 4095);
        // Forced P2 even on a flat-class window: row min 150 -> 2895
        send_one("force_p2", 2'd3, mk_win(8'd150, 8'd0, 8'd10, 8'd150, 8'd150),
                 flat(8'd200), flat(8'd200), 9'd256, 9'd256, 9'd256, 1'b1, 1'b0, 2895);
        // Horizontal edge: cls 10 -> P1 (column) = 150 -> 2895
        send_one("hedge", 2'd0, mk_win(8'd150, 8'd150, 8'd150, 8'd0, 8'd200),
                 flat(8'd200), flat(8'd200), 9'd256, 9'd256, 9'd256, 1'b1, 1'b0, 2895);
        // Gradient exactly at threshold (32) is not an edge: P0 = 0 -> 4095
        send_one("th_eq", 2'd0, mk_win(8'd150, 8'd0, 8'd32, 8'd150, 8'd150),
                 flat(8'd200), flat(8'd200), 9'd256, 9'd256, 9'd256, 1'b1, 1'b0, 4095);
        // One above threshold is an edge: P2 = 150 -> 2895
        send_one("th_gt", 2'd0, mk_win(8'd150, 8'd0, 8'd33, 8'd150, 8'd150),
                 flat(8'd200), flat(8'd200), 9'd256, 9'd256, 9'd256, 1'b1, 1'b0, 2895);
        // Saturating product: 255*511>>5=4072 -> 23 -> clamp 409
        send_one("clamp", 2'd0, flat(8'd255), flat(8'd255), flat(8'd255),
                 9'd511, 9'd511, 9'd511, 1'b1, 1'b0, 409);

        // Stream of 8 beats, value 10*(k+1), invA 256 -> t = 4095 - 80*(k+1)
        pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
        tx    = 0;
        rx    = 0;
        cyc   = 0;
        stall = 1'b0;
        held  = '0;
        mode  = 2'd0;
        inv_r = 9'd256;
        inv_g = 9'd256;
        inv_b = 9'd256;
        while (rx < 8 && cyc < 200) begin
            bus.out_ready = pat[cyc % 4];
            bus.in_valid  = (tx < 8);
            bus.win_r     = flat(DW'(10 * (tx + 1)));
            bus.win_g     = flat(DW'(10 * (tx + 1)));
            bus.win_b     = flat(DW'(10 * (tx + 1)));
            bus.in_sof    = (tx == 0);
            bus.in_eof    = (tx == 7);
            #1;
            chk("stream_in_ready", bus.in_ready, (!bus.out_valid) || bus.out_ready);
            if (stall) begin
                chk("stream_hold_valid", bus.out_valid, 1);
                chk("stream_hold_t", bus.t_out, held);
            end
            hs_in  = bus.in_valid && bus.in_ready;
            hs_out = bus.out_valid && bus.out_ready;
            if (hs_out) begin
                chk("stream_t", bus.t_out, 4095 - 80 * (rx + 1));
                chk("stream_sof", bus.out_sof, (rx == 0));
                chk("stream_eof", bus.out_eof, (rx == 7));
                $display("txn stream beat=%0d t_out=%0d cycle=%0d", rx, bus.t_out, cyc);
                rx++;
            end
            stall = bus.out_valid && !bus.out_ready;
            held  = bus.t_out;
            @(posedge clk); #1;
            if (hs_in) tx++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eof   = 1'b0;
        chk("stream_rx_count", rx, 8);
        chk("stream_tx_count", tx, 8);
        chk("stream_frame_done", frame_done, 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("stream_drain_empty", bus.out_valid, 0);
        end

        // invA latching across a frame: 256 captured, later 100 ignored
        send_one("lat_sof", 2'd0, flat(8'd100), flat(8'd100), flat(8'd100),
                 9'd256, 9'd256, 9'd256, 1'b1, 1'b0, 3295);
        send_one("lat_mid", 2'd0, flat(8'd100), flat(8'd100), flat(8'd100),
                 9'd100, 9'd100, 9'd100, 1'b0, 1'b0, 3295);
        send_one("lat_eof", 2'd0, flat(8'd100), flat(8'd100), flat(8'd100),
                 9'd100, 9'd100, 9'd100, 1'b0, 1'b1, 3295);
        // Single-pixel frame captures 100: 10000>>5=312 -> 3783
        send_one("single_px", 2'd0, flat(8'd100), flat(8'd100), flat(8'd100),
                 9'd100, 9'd100, 9'd100, 1'b1, 1'b1, 3783);

        // Reset with beats in flight and the output stalled
        bus.out_ready = 1'b0;
        mode          = 2'd0;
        inv_r         = 9'd256;
        inv_g         = 9'd256;
        inv_b         = 9'd256;
        bus.win_r     = flat(8'd50);
        bus.win_g     = flat(8'd50);
        bus.win_b     = flat(8'd50);
        bus.in_sof    = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_sof    = 1'b0;
        bus.win_r     = flat(8'd60);
        bus.win_g     = flat(8'd60);
        bus.win_b     = flat(8'd60);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", bus.out_valid, 1);
        rst = 1'b0;
        #1;
        chk("async_rst_valid", bus.out_valid, 0);
        chk("async_rst_t", bus.t_out, 0);
        @(negedge clk);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("post_rst_empty", bus.out_valid, 0);
        end
        // Latched invA was cleared: a non-sof beat sees invA 0 -> 4095
        send_one("post_rst_nosof", 2'd0, flat(8'd100), flat(8'd100), flat(8'd100),
                 9'd256, 9'd256, 9'd256, 1'b0, 1'b0, 4095);
        send_one("post_rst_sof", 2'd0, flat(8'd100), flat(8'd100), flat(8'd100),
                 9'd256, 9'd256, 9'd256, 1'b1, 1'b0, 3295);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
